cpu_system: RTL and testbench

CPU_SYSTEM -- requirements
Module: cpu_system

---
 rtl/cpu_system_if.sv | 28 ++
 rtl/cpu_system.sv | 171 +++++++++++++++++
 tb/tb_cpu_system.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_system_if.sv
// cpu_system_if: bundles the CPU's instruction-fetch and data-memory observation signals.
//   pc          - byte address of the current instruction (driven by CPU)
//   instruction - instruction word at pc (driven by external instruction memory)
//   read/write  - decoded load/store request of the current instruction
//   address     - data-memory byte address
//   writedata   - store data
//   readdata    - last loaded byte (held between loads)
//   busywait    - data-memory stall; pc and register file frozen while high
interface cpu_system_if;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;

  modport master (
    output pc, read, write, address, writedata, readdata, busywait,
    input  instruction
  );

  modport slave (
    input  pc, read, write, address, writedata, readdata, busywait,
    output instruction
  );
endinterface

// File: rtl/cpu_system.sv
// cpu_system: single-cycle 8-bit CPU with an internal multi-cycle data memory.
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - cpu_system_if master: pc out, instruction in, memory observation outputs
// Instruction fields: opcode [31:24], dest [23:16], src1 [15:8], src2/imm [7:0];
// register indices use the low 3 bits of each field.
module cpu_system #(
  parameter int unsigned MEM_CYCLES = 5,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  cpu_system_if.master bus
);

  localparam int unsigned AddrW = $clog2(MEM_DEPTH);

  localparam logic [7:0] OpLoadi = 8'h00;
  localparam logic [7:0] OpMov   = 8'h01;
  localparam logic [7:0] OpAdd   = 8'h02;
  localparam logic [7:0] OpSub   = 8'h03;
  localparam logic [7:0] OpAnd   = 8'h04;
  localparam logic [7:0] OpOr    = 8'h05;
  localparam logic [7:0] OpJ     = 8'h06;
  localparam logic [7:0] OpBeq   = 8'h07;
  localparam logic [7:0] OpLwd   = 8'h08;
  localparam logic [7:0] OpLwi   = 8'h09;
  localparam logic [7:0] OpSwd   = 8'h0A;
  localparam logic [7:0] OpSwi   = 8'h0B;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} mem_state_e;

  // Instruction fields
  logic [7:0] opcode;
  logic [7:0] dest;
  logic [7:0] imm;
  logic [2:0] rd_idx;
  logic [2:0] rs1_idx;
  logic [2:0] rs2_idx;

  assign opcode  = bus.instruction[31:24];
  assign dest    = bus.instruction[23:16];
  assign imm     = bus.instruction[7:0];
  assign rd_idx  = bus.instruction[18:16];
  assign rs1_idx = bus.instruction[10:8];
  assign rs2_idx = bus.instruction[2:0];

  // State
  logic [31:0]      pc_q;
  logic [7:0]       rf_q [8];
  logic [7:0]       mem_q [MEM_DEPTH];
  mem_state_e       state_q;
  logic [3:0]       cnt_q;
  logic [7:0]       readdata_q;

  // Decode / datapath
  logic [7:0]  rs1_val;
  logic [7:0]  rs2_val;
  logic [7:0]  diff;
  logic        rf_we;
  logic [7:0]  rf_wdata;
  logic        is_read;
  logic        is_write;
  logic        use_imm_addr;
  logic        branch_taken;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] pc_next;
  logic        busywait;
  logic [AddrW-1:0] mem_idx;

  assign rs1_val = rf_q[rs1_idx];
  assign rs2_val = rf_q[rs2_idx];
  assign diff    = rs1_val - rs2_val;

  always_comb begin
    rf_we        = 1'b0;
    rf_wdata     = '0;
    is_read      = 1'b0;
    is_write     = 1'b0;
    use_imm_addr = 1'b0;
    branch_taken = 1'b0;
    case (opcode)
      OpLoadi: begin rf_we = 1'b1; rf_wdata = imm;               end
      OpMov:   begin rf_we = 1'b1; rf_wdata = rs2_val;           end
      OpAdd:   begin rf_we = 1'b1; rf_wdata = rs1_val + rs2_val; end
      OpSub:   begin rf_we = 1'b1; rf_wdata = diff;              end
      OpAnd:   begin rf_we = 1'b1; rf_wdata = rs1_val & rs2_val; end
      OpOr:    begin rf_we = 1'b1; rf_wdata = rs1_val | rs2_val; end
      OpJ:     branch_taken = 1'b1;
      OpBeq:   branch_taken = (diff == 8'd0);
      // Loads write back the byte latched by the memory at the end of its busy phase.
      OpLwd:   begin is_read = 1'b1; rf_we = 1'b1; rf_wdata = readdata_q; end
      OpLwi:   begin
        is_read = 1'b1; use_imm_addr = 1'b1; rf_we = 1'b1; rf_wdata = readdata_q;
      end
      OpSwd:   is_write = 1'b1;
      OpSwi:   begin is_write = 1'b1; use_imm_addr = 1'b1; end
      default: ;  // undefined opcodes: NOP
    endcase
  end

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{22{dest[7]}}, dest, 2'b00};
  assign pc_next  = branch_taken ? pc_plus4 + br_off : pc_plus4;

  // Stall every cycle of a memory instruction except the final DONE cycle.
  assign busywait = (is_read | is_write) && (state_q != StDone);

  assign bus.pc        = pc_q;
  assign bus.read      = is_read;
  assign bus.write     = is_write;
  assign bus.address   = use_imm_addr ? imm : rs2_val;
  assign bus.writedata = rs1_val;
  assign bus.readdata  = readdata_q;
  assign bus.busywait  = busywait;

  assign mem_idx = bus.address[AddrW-1:0];

  // CPU state: pc and register file advance only when not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (!busywait) begin
      pc_q <= pc_next;
      if (rf_we) rf_q[rd_idx] <= rf_wdata;
    end
  end

  // Data memory FSM. The IDLE cycle counts as the first busy cycle, so the
  // access completes on the edge that brings the counter to MEM_CYCLES, giving
  // MEM_CYCLES stalled cycles followed by one DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      readdata_q <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (is_read | is_write) begin
            state_q <= StBusy;
            cnt_q   <= 4'd1;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(MEM_CYCLES - 1)) begin
            if (is_write) begin
              mem_q[mem_idx] <= bus.writedata;
            end else if (is_read) begin
              readdata_q <= mem_q[mem_idx];
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_system.sv
module tb_cpu_system;

  localparam int unsigned MemCycles = 5;
  localparam logic [31:0] Nop = 32'hFF00_0000;

  logic clk;
  logic rst_n;
  cpu_system_if bus ();

  logic [31:0] imem [64];
  assign bus.instruction = imem[bus.pc[7:2]];

  cpu_system #(
    .MEM_CYCLES (MemCycles),
    .MEM_DEPTH  (256)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] dut_regs();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = dut.rf_q[i];
    return r;
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = Nop;
  endtask

  // Reset pulse ending on a falling edge; the next rising edge executes PC=0.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Memory instruction at exp_pc: checks request decode, stall pattern and PC hold.
  task automatic mem_seq(input string nm, input logic [31:0] exp_pc, input logic exp_rd,
                         input logic exp_wr, input logic [7:0] exp_addr);
    logic [15:0] busy_bits;
    int          held;
    busy_bits = '0;
    held      = 1;
    chk({nm, "_read"},  64'(bus.read),    64'(exp_rd));
    chk({nm, "_write"}, 64'(bus.write),   64'(exp_wr));
    chk({nm, "_addr"},  64'(bus.address), 64'(exp_addr));
    for (int c = 0; c < int'(MemCycles) + 1; c++) begin
      busy_bits[c] = bus.busywait;
      if (bus.pc !== exp_pc) held = 0;
      @(negedge clk);
    end
    chk({nm, "_busy_pattern"}, 64'(busy_bits), 64'((1 << MemCycles) - 1));
    chk({nm, "_pc_held"}, 64'(held), 64'd1);
    chk({nm, "_pc_after"}, 64'(bus.pc), 64'(exp_pc + 32'd4));
  endtask

  // Reference model: architectural state stepped one whole instruction at a time.
  logic [31:0] m_pc;
  logic [7:0]  m_rf [8];
  logic [7:0]  m_mem [256];
  logic [7:0]  m_rd;

  task automatic model_reset();
    m_pc = '0;
    m_rd = '0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
  endtask

  function automatic logic [63:0] model_regs();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = m_rf[i];
    return r;
  endfunction

  task automatic model_step(output int cycles);
    logic [31:0] ins;
    logic [7:0]  op, d, s1, s2, a, b;
    int          off;
    ins = imem[m_pc[7:2]];
    op = ins[31:24]; d = ins[23:16]; s1 = ins[15:8]; s2 = ins[7:0];
    a = m_rf[s1 % 8];
    b = m_rf[s2 % 8];
    off = $signed(d);
    cycles = 1;
    case (op)
      8'h00: m_rf[d % 8] = s2;
      8'h01: m_rf[d % 8] = b;
      8'h02: m_rf[d % 8] = 8'((int'(a) + int'(b)) % 256);
      8'h03: m_rf[d % 8] = 8'((int'(a) - int'(b) + 256) % 256);
      8'h04: m_rf[d % 8] = a & b;
      8'h05: m_rf[d % 8] = a | b;
      8'h06: m_pc = m_pc + 32'(off * 4);
      8'h07: if (a == b) m_pc = m_pc + 32'(off * 4);
      8'h08: begin m_rd = m_mem[b];  m_rf[d % 8] = m_rd; cycles = MemCycles + 1; end
      8'h09: begin m_rd = m_mem[s2]; m_rf[d % 8] = m_rd; cycles = MemCycles + 1; end
      8'h0A: begin m_mem[b]  = a; cycles = MemCycles + 1; end
      8'h0B: begin m_mem[s2] = a; cycles = MemCycles + 1; end
      default: ;
    endcase
    m_pc = m_pc + 32'd4;
  endtask

  typedef struct {
    string      name;
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } alu_vec_t;

  alu_vec_t vecs [8];

  initial begin
    vecs[0] = '{"add_wrap",   8'h02, 8'd200, 8'd100, 8'd44};
    vecs[1] = '{"sub_neg",    8'h03, 8'd100, 8'd200, 8'd156};
    vecs[2] = '{"add_to_0",   8'h02, 8'hFF,  8'h01,  8'h00};
    vecs[3] = '{"sub_equal",  8'h03, 8'd5,   8'd5,   8'd0};
    vecs[4] = '{"sub_pos",    8'h03, 8'd7,   8'd3,   8'd4};
    vecs[5] = '{"and",        8'h04, 8'hF0,  8'h3C,  8'h30};
    vecs[6] = '{"or",         8'h05, 8'hF0,  8'h0F,  8'hFF};
    vecs[7] = '{"mov",        8'h01, 8'h01,  8'hAB,  8'hAB};

    rst_n = 1'b0;
    clear_imem();
    #1;
    chk("reset_pc",       64'(bus.pc),       64'd0);
    chk("reset_busy",     64'(bus.busywait), 64'd0);
    chk("reset_readdata", 64'(bus.readdata), 64'd0);
    chk("reset_regs",     dut_regs(),        64'd0);

    // Table-driven ALU vectors: loadi r1,a; loadi r2,b; op r3,r1,r2
    for (int i = 0; i < 8; i++) begin
      clear_imem();
      imem[0] = {8'h00, 8'h01, 8'h00, vecs[i].a};
      imem[1] = {8'h00, 8'h02, 8'h00, vecs[i].b};
      imem[2] = {vecs[i].op, 8'h03, 8'h01, 8'h02};
      do_reset();
      repeat (3) @(negedge clk);
      chk({vecs[i].name, "_r3"}, 64'(dut.rf_q[3]), 64'(vecs[i].exp));
      chk({vecs[i].name, "_pc"}, 64'(bus.pc), 64'd12);
    end

    // Load/store program
    clear_imem();
    imem[0] = 32'h0003_0007;  // loadi r3,7
    imem[1] = 32'h0005_0006;  // loadi r5,6
    imem[2] = 32'h0004_0004;  // loadi r4,4
    imem[3] = 32'h0A00_0304;  // swd r3,r4
    imem[4] = 32'h0B00_0302;  // swi r3,0x02
    imem[5] = 32'h0801_0004;  // lwd r1,r4
    imem[6] = 32'h0907_0002;  // lwi r7,0x02
    do_reset();
    chk("prog_pc0", 64'(bus.pc), 64'd0);
    repeat (3) @(negedge clk);
    chk("prog_pc12", 64'(bus.pc), 64'd12);
    chk("prog_r3", 64'(dut.rf_q[3]), 64'd7);
    chk("prog_r5", 64'(dut.rf_q[5]), 64'd6);
    chk("prog_r4", 64'(dut.rf_q[4]), 64'd4);
    chk("swd_wdata", 64'(bus.writedata), 64'd7);
    mem_seq("swd", 32'd12, 1'b0, 1'b1, 8'd4);
    chk("swd_mem4", 64'(dut.mem_q[4]), 64'd7);
    mem_seq("swi", 32'd16, 1'b0, 1'b1, 8'd2);
    chk("swi_mem2", 64'(dut.mem_q[2]), 64'd7);
    mem_seq("lwd", 32'd20, 1'b1, 1'b0, 8'd4);
    chk("lwd_r1", 64'(dut.rf_q[1]), 64'd7);
    chk("lwd_readdata", 64'(bus.readdata), 64'd7);
    mem_seq("lwi", 32'd24, 1'b1, 1'b0, 8'd2);
    chk("lwi_r7", 64'(dut.rf_q[7]), 64'd7);
    chk("prog_pc28", 64'(bus.pc), 64'd28);
    repeat (2) @(negedge clk);
    chk("readdata_hold", 64'(bus.readdata), 64'd7);

    // Branches
    clear_imem();
    imem[0] = 32'h0001_0005;  // loadi r1,5
    imem[1] = 32'h0002_0005;  // loadi r2,5
    imem[2] = 32'h0701_0102;  // beq +1 r1,r2
    imem[3] = 32'h0006_0009;  // loadi r6,9 (must be skipped on first pass)
    imem[4] = 32'h06FE_0000;  // j -2
    do_reset();
    repeat (3) @(negedge clk);
    chk("beq_taken_pc", 64'(bus.pc), 64'd16);
    chk("beq_skip_r6", 64'(dut.rf_q[6]), 64'd0);
    @(negedge clk);
    chk("j_back_pc", 64'(bus.pc), 64'd12);
    imem[1] = 32'h0002_0006;  // loadi r2,6 -> beq not taken
    do_reset();
    repeat (3) @(negedge clk);
    chk("beq_not_taken_pc", 64'(bus.pc), 64'd12);

    // Reset in the third stall cycle of a store aborts it
    clear_imem();
    imem[0] = 32'h0003_0009;  // loadi r3,9
    imem[1] = 32'h0B00_0310;  // swi r3,0x10
    do_reset();
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 64'(bus.busywait), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_pc",   64'(bus.pc),       64'd0);
    chk("abort_busy", 64'(bus.busywait), 64'd0);
    repeat (10) @(negedge clk);
    chk("abort_mem",  64'(dut.mem_q[8'h10]), 64'd0);
    chk("abort_regs", dut_regs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_restart_pc", 64'(bus.pc), 64'd4);

    // Random programs against the reference model
    for (int prog = 0; prog < 3; prog++) begin
      for (int i = 0; i < 64; i++) begin
        logic [7:0] op;
        op = 8'($urandom_range(0, 13));
        if (op > 8'h0B) op = 8'hC0 | 8'($urandom_range(0, 63));
        imem[i] = {op, 24'($urandom)};
      end
      do_reset();
      model_reset();
      for (int s = 0; s < 60; s++) begin
        int cyc, busy_cnt;
        chk("rnd_pc_before", 64'(bus.pc), 64'(m_pc));
        model_step(cyc);
        busy_cnt = 0;
        for (int c = 0; c < cyc; c++) begin
          if (bus.busywait) busy_cnt++;
          @(negedge clk);
        end
        chk("rnd_busy_cycles", 64'(busy_cnt), 64'(cyc - 1));
        chk("rnd_regs", dut_regs(), model_regs());
        chk("rnd_readdata", 64'(bus.readdata), 64'(m_rd));
      end
      begin
        int mism;
        mism = 0;
        for (int i = 0; i < 256; i++) if (dut.mem_q[i] !== m_mem[i]) mism++;
        chk("rnd_mem_mismatches", 64'(mism), 64'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
